timer_apb_regs: RTL and testbench

APB slave register block for the 8-bit timer. It is the responder to the CPU-side APB initiator. It decodes APB transfers to the TDR, TCR and TSR registers, inserts a configurable number of wait states, and drives the configuration outputs of the timer core. It also captures overflow and underflow events from the core into sticky status flags. It sits between the APB interconnect and the timer counter datapath.

---
 rtl/timer_apb_regs.sv | 166 ++++++++++++++++
 tb/tb_timer_apb_regs.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB slave register block for the 8-bit timer.
// Decodes TDR (0x00), TCR (0x01) and TSR (0x02) and inserts WAIT_STATES
// wait cycles per access. It drives the timer configuration outputs and
// captures overflow/underflow pulses into sticky status flags.
//
// Ports:
//   pclk, presetn         APB clock, async active-low reset
//   psel, penable         APB select / access-phase strobe
//   pwrite, paddr, pwdata APB direction, address, write data
//   prdata, pready        read data (valid with pready), transfer done
//   pslverr               error response for addresses above 0x02
//   tdr                   counter load value
//   tcr_load, tcr_up_down TCR[7] load request, TCR[5] count direction
//   tcr_en, tcr_cks       TCR[4] enable, TCR[1:0] clock divider select
//   ovf_set, udf_set      single-cycle event pulses from the timer core
//   tmr_ovf, tmr_udf      TSR[1] / TSR[0] sticky flags

module timer_apb_regs #(
    parameter int WAIT_STATES = 0
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] tdr,
    output logic       tcr_load,
    output logic       tcr_up_down,
    output logic       tcr_en,
    output logic [1:0] tcr_cks,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic       tmr_ovf,
    output logic       tmr_udf
);

    localparam logic [1:0] LP_WAIT = 2'(WAIT_STATES);
    localparam logic [7:0] LP_TCR_MASK = 8'b1011_0011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_wait;
    logic [1:0] w_wait_next;

    logic [7:0] r_tdr;
    logic [7:0] r_tcr;
    logic       r_ovf;
    logic       r_udf;

    logic       w_access;
    logic       w_done;
    logic       w_addr_ok;
    logic       w_wr;
    logic       w_tsr_wr;
    logic [7:0] w_rdata;

    // The state register lags the bus by one cycle: SETUP means the
    // previous cycle was a setup phase, so an access cycle is recognised
    // from the live psel/penable while the FSM is in SETUP or ACCESS.
    assign w_access  = psel & penable & (r_state != S_IDLE);
    assign w_done    = w_access & (r_wait == 2'd0);
    assign w_addr_ok = (paddr <= 8'h02);
    assign w_wr      = w_done & pwrite & w_addr_ok;
    assign w_tsr_wr  = w_wr & (paddr == 8'h02);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
            r_wait  <= 2'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wait_next = r_wait;
        case (r_state)
            S_IDLE: begin
                if (psel && !penable) begin
                    w_next      = S_SETUP;
                    w_wait_next = LP_WAIT;
                end
            end
            S_SETUP, S_ACCESS: begin
                if (!psel) begin
                    // psel dropped before completion: abort
                    w_next      = S_IDLE;
                    w_wait_next = 2'd0;
                end else if (!penable) begin
                    w_next      = S_SETUP;
                    w_wait_next = LP_WAIT;
                end else if (w_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_next      = S_ACCESS;
                    w_wait_next = r_wait - 2'd1;
                end
            end
            default: begin
                w_next      = S_IDLE;
                w_wait_next = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_rdata = 8'h00;
        case (paddr)
            8'h00:   w_rdata = r_tdr;
            8'h01:   w_rdata = r_tcr;
            8'h02:   w_rdata = {6'b0, r_ovf, r_udf};
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tdr <= 8'h00;
            r_tcr <= 8'h00;
        end else if (w_wr) begin
            if (paddr == 8'h00) begin
                r_tdr <= pwdata;
            end
            if (paddr == 8'h01) begin
                r_tcr <= pwdata & LP_TCR_MASK;
            end
        end
    end

    // Software writes 0 to clear; a same-cycle hardware set wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= ovf_set | (r_ovf & ~(w_tsr_wr & ~pwdata[1]));
            r_udf <= udf_set | (r_udf & ~(w_tsr_wr & ~pwdata[0]));
        end
    end

    assign pready      = w_done;
    assign pslverr     = w_done & ~w_addr_ok;
    assign prdata      = w_done ? w_rdata : 8'h00;

    assign tdr         = r_tdr;
    assign tcr_load    = r_tcr[7];
    assign tcr_up_down = r_tcr[5];
    assign tcr_en      = r_tcr[4];
    assign tcr_cks     = r_tcr[1:0];
    assign tmr_ovf     = r_ovf;
    assign tmr_udf     = r_udf;

endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs: bench for timer_apb_regs with WAIT_STATES 0, 2, 3
// sharing one APB bus; a transaction-level model checks every cycle.

module tb_timer_apb_regs;

    localparam int WS[3] = '{0, 2, 3};

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic       ovf_set = 1'b0;
    logic       udf_set = 1'b0;

    logic [7:0] prdata_w[3];
    logic       pready_w[3];
    logic       pslverr_w[3];
    logic [7:0] tdr_w[3];
    logic       load_w[3];
    logic       ud_w[3];
    logic       en_w[3];
    logic [1:0] cks_w[3];
    logic       ovf_w[3];
    logic       udf_w[3];

    int n_vec = 0;
    int n_err = 0;

    always #10 pclk = ~pclk;

    timer_apb_regs #(.WAIT_STATES(0)) u_w0 (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]),
        .tdr(tdr_w[0]), .tcr_load(load_w[0]), .tcr_up_down(ud_w[0]),
        .tcr_en(en_w[0]), .tcr_cks(cks_w[0]),
        .ovf_set(ovf_set), .udf_set(udf_set),
        .tmr_ovf(ovf_w[0]), .tmr_udf(udf_w[0])
    );

    timer_apb_regs #(.WAIT_STATES(2)) u_w2 (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]),
        .tdr(tdr_w[1]), .tcr_load(load_w[1]), .tcr_up_down(ud_w[1]),
        .tcr_en(en_w[1]), .tcr_cks(cks_w[1]),
        .ovf_set(ovf_set), .udf_set(udf_set),
        .tmr_ovf(ovf_w[1]), .tmr_udf(udf_w[1])
    );

    timer_apb_regs #(.WAIT_STATES(3)) u_w3 (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]),
        .tdr(tdr_w[2]), .tcr_load(load_w[2]), .tcr_up_down(ud_w[2]),
        .tcr_en(en_w[2]), .tcr_cks(cks_w[2]),
        .ovf_set(ovf_set), .udf_set(udf_set),
        .tmr_ovf(ovf_w[2]), .tmr_udf(udf_w[2])
    );

    function automatic logic [7:0] tcrv(input int k);
        return {load_w[k], 1'b0, ud_w[k], en_w[k], 2'b00, cks_w[k]};
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[W=%0d] t=%0t: got %0h want %0h",
                     nm, WS[k], $time, act, exp);
        end
    endtask

    // Transaction-level model: registers plus "inside a transfer" and
    // the number of access cycles already spent in it.
    logic [7:0] m_tdr[3];
    logic [7:0] m_tcr[3];
    logic       m_ovf[3];
    logic       m_udf[3];
    logic       m_in[3];
    int         m_acc[3];

    function automatic logic [7:0] m_reg(input int k, input logic [7:0] a);
        if (a == 8'h00) return m_tdr[k];
        if (a == 8'h01) return m_tcr[k];
        if (a == 8'h02) return {6'b0, m_ovf[k], m_udf[k]};
        return 8'h00;
    endfunction

    always @(posedge pclk or negedge presetn) begin
        for (int k = 0; k < 3; k++) begin
            if (!presetn) begin
                m_tdr[k] = 8'h00;
                m_tcr[k] = 8'h00;
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
                m_in[k]  = 1'b0;
                m_acc[k] = 0;
            end else begin
                if (!psel) begin
                    m_in[k] = 1'b0;
                end else if (!penable) begin
                    m_in[k]  = 1'b1;
                    m_acc[k] = 0;
                end else if (m_in[k]) begin
                    if (m_acc[k] == WS[k]) begin
                        m_in[k] = 1'b0;
                        if (pwrite) begin
                            if (paddr == 8'h00) m_tdr[k] = pwdata;
                            if (paddr == 8'h01) m_tcr[k] = pwdata & 8'hB3;
                            if (paddr == 8'h02) begin
                                m_ovf[k] = m_ovf[k] & pwdata[1];
                                m_udf[k] = m_udf[k] & pwdata[0];
                            end
                        end
                    end else begin
                        m_acc[k] = m_acc[k] + 1;
                    end
                end
                m_ovf[k] = m_ovf[k] | ovf_set;
                m_udf[k] = m_udf[k] | udf_set;
            end
        end
    end

    always @(negedge pclk) begin
        #3;
        for (int k = 0; k < 3; k++) begin
            logic rdy;
            rdy = m_in[k] && psel && penable && (m_acc[k] == WS[k]);
            chk("pready", k, pready_w[k], rdy);
            chk("pslverr", k, pslverr_w[k], rdy && (paddr > 8'h02));
            chk("prdata", k, prdata_w[k], rdy ? m_reg(k, paddr) : 8'h00);
            chk("tdr", k, tdr_w[k], m_tdr[k]);
            chk("tcr", k, tcrv(k), m_tcr[k]);
            chk("tmr_ovf", k, ovf_w[k], m_ovf[k]);
            chk("tmr_udf", k, udf_w[k], m_udf[k]);
        end
    end

    // Full transfer paced by the slowest slave (W=3); the faster ones
    // finish earlier and ignore the rest of the access phase.
    task automatic xfer(input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input logic exp_err, input logic udf_at_end);
        int   cyc;
        int   rc[3];
        logic got[3];
        logic done;
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got[k] = 1'b0;
            rc[k]  = 0;
        end
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 2;
        for (int i = 0; i < 12 && !done; i++) begin
            #3;
            for (int k = 0; k < 3; k++) begin
                if (!got[k] && pready_w[k]) begin
                    got[k] = 1'b1;
                    rc[k]  = cyc;
                end
            end
            if (pready_w[2]) begin
                done = 1'b1;
                chk("lit_pslverr", 2, pslverr_w[2], exp_err);
                if (!wr) chk("lit_prdata", 2, prdata_w[2], exp_rd);
                if (udf_at_end) udf_set = 1'b1;
            end else begin
                @(negedge pclk);
                cyc++;
            end
        end
        if (!done) chk("pready_timeout", 2, 0, 1);
        for (int k = 0; k < 3; k++)
            chk("xfer_cycles", k, rc[k], 2 + WS[k]);
        if (udf_at_end) begin
            @(negedge pclk);
            udf_set = 1'b0; psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic abort_wr(input logic [7:0] addr, input logic [7:0] wd,
                            input int nacc);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
        @(negedge pclk);
        penable = 1'b1;
        repeat (nacc - 1) @(negedge pclk);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge pclk);
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_tdr", k, tdr_w[k], 8'h00);
            chk("rst_tcr", k, tcrv(k), 8'h00);
            chk("rst_pready", k, pready_w[k], 1'b0);
        end
        @(negedge pclk);
        presetn = 1'b1;

        xfer(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);

        xfer(1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 1'b0);
        chk("lit_tcr_outs", 2, tcrv(2), 8'hB3);

        xfer(1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
        idle();
        #3;
        for (int k = 0; k < 3; k++) chk("lit_tdr_a5", k, tdr_w[k], 8'hA5);

        @(negedge pclk);
        ovf_set = 1'b1;
        @(negedge pclk);
        ovf_set = 1'b0;
        #3;
        chk("lit_tmr_ovf", 0, ovf_w[0], 1'b1);
        xfer(1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);
        xfer(1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
        xfer(1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1);
        xfer(1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("lit_tmr_udf", 0, udf_w[0], 1'b1);

        xfer(1'b1, 8'h05, 8'h77, 8'h00, 1'b1, 1'b0);
        xfer(1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
        xfer(1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 1'b0);
        xfer(1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
        xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0);

        xfer(1'b1, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);
        chk("lit_tdr_pre", 2, tdr_w[2], 8'hA5);
        idle();
        #3;
        chk("lit_tdr_3c", 2, tdr_w[2], 8'h3C);

        abort_wr(8'h01, 8'h30, 2);
        #3;
        chk("lit_abort_w2", 1, tcrv(1), 8'hB3);
        chk("lit_abort_w3", 2, tcrv(2), 8'hB3);
        chk("lit_noabort_w0", 0, tcrv(0), 8'h30);

        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h01; pwdata = 8'h30;
        @(negedge pclk);
        penable = 1'b1;
        #3;
        chk("lit_pre_rst_rdy", 0, pready_w[0], 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        chk("lit_rst_rdy", 0, pready_w[0], 1'b0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) chk("lit_rst_tcr", k, tcrv(k), 8'h00);

        xfer(1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0);
        idle();
        repeat (2) @(negedge pclk);
        #5;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
